matmul_job_sched: RTL
=====================

// Module: matmul_job_sched
// PURPOSE
//  Job scheduler in front of the 4x4 matmul + 2x2 avg-pool engine. Queues job
//  descriptors (A/B/C base addresses + tag), launches them one at a time via
//  the engine kick_start/ready handshake, and drives the engine base addresses.
//  Watchdogs each job and returns a per-job completion record (tag, status).
// PARAMETERS
//  FIFO_DEPTH  4     job descriptor queue depth (power of 2, >=2)
//  ADDR_W      10    engine memory address width
//  TAG_W       4     job tag width
//  TIMEOUT     1023  max cycles in WAIT_DONE before a job is declared hung
//  CNT_W       8     width of completed-job counter
// PORTS
//  clk          in   1       clock
//  rst          in   1       async reset, active-high
//  job_valid    in   1       descriptor valid
//  job_ready    out  1       queue can accept (= !full)
//  job_base_a   in   ADDR_W  A base address
//  job_base_b   in   ADDR_W  B base address
//  job_base_c   in   ADDR_W  C (pooled result) address
//  job_tag      in   TAG_W   caller tag, echoed on completion
//  eng_kick     out  1       1-cycle kick_start pulse to engine
//  eng_ready    in   1       engine ready (high = idle)
//  eng_abort    out  1       1-cycle engine reset request on timeout
//  eng_base_a/b/c out ADDR_W base addresses of job in flight
//  done_valid   out  1       completion record valid
//  done_ready   in   1       completion record consumed
//  done_tag     out  TAG_W   tag of completed job
//  done_err     out  1       0 = ok, 1 = timeout/no-start
//  busy         out  1       job in flight or queue non-empty
//  jobs_done    out  CNT_W   count of ok completions, wraps
// BEHAVIOUR
//  Reset: all outputs 0 except job_ready=1; queue empty; state IDLE.
//  Queue: push when job_valid&job_ready. Full: job_ready=0, no push. Pop
//   only in IDLE. Push+pop same cycle legal when not full; occupancy unchanged.
//  FSM: IDLE -> LAUNCH -> WAIT_START -> WAIT_DONE -> REPORT -> IDLE.
//   IDLE: if queue non-empty & eng_ready & !done_valid: pop head, load
//    eng_base_*/tag regs -> LAUNCH. Job pushed into empty queue launches no
//    earlier than the cycle after the push.
//   LAUNCH: eng_kick=1 exactly this cycle -> WAIT_START.
//   WAIT_START: wait eng_ready=0 (engine drops ready 2 cycles after kick);
//    if still high after 4 cycles -> err=1 -> REPORT.
//   WAIT_DONE: cycle counter from 0; eng_ready=1 -> err=0 -> REPORT;
//    counter==TIMEOUT -> eng_abort=1 one cycle, err=1 -> REPORT.
//   REPORT: done_valid<=1, done_tag/done_err loaded; jobs_done+1 if err=0
//    (wraps 2^CNT_W-1 -> 0) -> IDLE.
//  Completion: done_valid held with stable tag/err until done_ready; cleared
//   next edge. No new launch while done_valid=1 (backpressure).
//  eng_base_* change only at pop; stable from LAUNCH until next pop.
//  busy = (state!=IDLE) | !empty | done_valid.
//  Reset mid-job: everything to reset values immediately; queued jobs lost;
//   eng_kick/eng_abort deasserted asynchronously.
// TESTING
//  1. Push 1 job {A=0x000,B=0x100,C=0x200,tag=3}; engine model done after 60
//     cycles -> one eng_kick pulse, eng_base_*=job values, done tag=3 err=0,
//     jobs_done=1.
//  2. Push 5 jobs back-to-back, FIFO_DEPTH=4, engine busy -> job_ready low
//     after 4th push, 5th held until first pop; completion tags in push order.
//  3. Engine never drops ready after kick -> done_err=1 within 7 cycles of
//     kick, no eng_abort, jobs_done unchanged.
//  4. Engine never returns ready -> eng_abort pulse TIMEOUT cycles into
//     WAIT_DONE, done_err=1, next queued job then launches.
//  5. Hold done_ready=0 for 20 cycles with 2 jobs queued -> no eng_kick
//     while done_valid=1, done_tag stable; launch follows release.
//  6. Assert rst during WAIT_DONE -> all outputs to reset values same cycle,
//     job_ready=1, busy=0; fresh job after release runs normally.

Source files
------------

// File: rtl/matmul_job_sched.sv
// Job scheduler for the 4x4 matmul + 2x2 avg-pool engine.
// Queues job descriptors, launches them one at a time over the engine
// kick/ready handshake, watchdogs each job and returns a completion record.
module matmul_job_sched #(
   parameter int FIFO_DEPTH = 4,
   parameter int ADDR_W     = 10,
   parameter int TAG_W      = 4,
   parameter int TIMEOUT    = 1023,
   parameter int CNT_W      = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              job_valid,
   output logic              job_ready,
   input  logic [ADDR_W-1:0] job_base_a,
   input  logic [ADDR_W-1:0] job_base_b,
   input  logic [ADDR_W-1:0] job_base_c,
   input  logic [TAG_W-1:0]  job_tag,
   output logic              eng_kick,
   input  logic              eng_ready,
   output logic              eng_abort,
   output logic [ADDR_W-1:0] eng_base_a,
   output logic [ADDR_W-1:0] eng_base_b,
   output logic [ADDR_W-1:0] eng_base_c,
   output logic              done_valid,
   input  logic              done_ready,
   output logic [TAG_W-1:0]  done_tag,
   output logic              done_err,
   output logic              busy,
   output logic [CNT_W-1:0]  jobs_done
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int TMO_W = $clog2(TIMEOUT + 1);
   // Cycles the engine gets to drop ready after a kick before the job is failed
   localparam logic [TMO_W-1:0] START_LAST = TMO_W'(3);

   typedef struct packed {
      logic [ADDR_W-1:0] a;
      logic [ADDR_W-1:0] b;
      logic [ADDR_W-1:0] c;
      logic [TAG_W-1:0]  tag;
   } job_t;

   typedef enum logic [2:0] {
      S_IDLE, S_LAUNCH, S_WAIT_START, S_WAIT_DONE, S_REPORT
   } state_t;

   job_t             mem [FIFO_DEPTH];
   job_t             job_in, head;
   logic [PTR_W:0]   wr_ptr, rd_ptr;
   logic             empty, full, push, pop;
   state_t           state;
   logic [TMO_W-1:0] cnt;
   logic             err_r;
   logic [TAG_W-1:0] tag_r;

   // Extra pointer MSB distinguishes full from empty when the indices match
   assign empty  = (wr_ptr == rd_ptr);
   assign full   = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                   (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
   assign push   = job_valid && !full;
   // Pop looks at registered occupancy, so a job pushed into an empty queue
   // is launched at the earliest one cycle after its push
   assign pop    = (state == S_IDLE) && !empty && eng_ready && !done_valid;
   assign job_in = '{a: job_base_a, b: job_base_b, c: job_base_c, tag: job_tag};
   assign head   = mem[rd_ptr[PTR_W-1:0]];

   assign job_ready = !full;
   assign busy      = (state != S_IDLE) || !empty || done_valid;

   // Descriptor storage; contents are don't-care until pushed
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr[PTR_W-1:0]] <= job_in;
   end

   // Queue pointers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // Launch/watchdog/report FSM with registered engine and completion outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= S_IDLE;
         eng_kick   <= 1'b0;
         eng_abort  <= 1'b0;
         eng_base_a <= '0;
         eng_base_b <= '0;
         eng_base_c <= '0;
         tag_r      <= '0;
         err_r      <= 1'b0;
         cnt        <= '0;
         done_valid <= 1'b0;
         done_tag   <= '0;
         done_err   <= 1'b0;
         jobs_done  <= '0;
      end else begin
         eng_kick  <= 1'b0;
         eng_abort <= 1'b0;
         if (done_valid && done_ready) done_valid <= 1'b0;
         case (state)
            S_IDLE: begin
               if (pop) begin
                  eng_base_a <= head.a;
                  eng_base_b <= head.b;
                  eng_base_c <= head.c;
                  tag_r      <= head.tag;
                  eng_kick   <= 1'b1;
                  state      <= S_LAUNCH;
               end
            end
            S_LAUNCH: begin
               cnt   <= '0;
               state <= S_WAIT_START;
            end
            S_WAIT_START: begin
               if (!eng_ready) begin
                  cnt   <= '0;
                  state <= S_WAIT_DONE;
               end else if (cnt == START_LAST) begin
                  err_r <= 1'b1;
                  state <= S_REPORT;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            S_WAIT_DONE: begin
               if (eng_ready) begin
                  err_r <= 1'b0;
                  state <= S_REPORT;
               end else if (cnt == TMO_W'(TIMEOUT)) begin
                  eng_abort <= 1'b1;
                  err_r     <= 1'b1;
                  state     <= S_REPORT;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            S_REPORT: begin
               done_valid <= 1'b1;
               done_tag   <= tag_r;
               done_err   <= err_r;
               if (!err_r) jobs_done <= jobs_done + 1'b1;
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
